// File: rtl/onehot_encoder_pkg.sv
// -----------------------------------------------------------------------------
// onehot_encoder_pkg
// Shared definitions for the one-hot event encoder:
//   state_t    - output stage state encoding (EMPTY / FULL)
//   NUM_SRC    - number of event request lines
//   CODE_W     - width of the binary source index
//   CNT_W      - width of the pending-event counter (must hold 0..NUM_SRC)
//   count_ones - population count of a pending vector
// -----------------------------------------------------------------------------
package onehot_encoder_pkg;

   localparam int NUM_SRC = 8;
   localparam int CODE_W  = 3;
   localparam int CNT_W   = 4;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   function automatic logic [CNT_W-1:0] count_ones(input logic [NUM_SRC-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         n = n + CNT_W'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/onehot_encoder_if.sv
// -----------------------------------------------------------------------------
// onehot_encoder_if
// Bundles the event inputs and the code handshake of the encoder.
//   in_line    - event request lines, bit i = source i
//   code       - binary index of the granted source
//   code_valid - code holds an undelivered event
//   code_ready - consumer accepts code (transfer when valid and ready)
//   overflow   - one-cycle pulse, event arrived on an already pending source
//   pend_cnt   - number of pending events not yet loaded to code
// Modports: master = encoder side, slave = source/consumer side.
// -----------------------------------------------------------------------------
interface onehot_encoder_if;
   import onehot_encoder_pkg::*;

   logic [NUM_SRC-1:0] in_line;
   logic [CODE_W-1:0]  code;
   logic               code_valid;
   logic               code_ready;
   logic               overflow;
   logic [CNT_W-1:0]   pend_cnt;

   modport master (
      input  in_line,
      input  code_ready,
      output code,
      output code_valid,
      output overflow,
      output pend_cnt
   );

   modport slave (
      output in_line,
      output code_ready,
      input  code,
      input  code_valid,
      input  overflow,
      input  pend_cnt
   );

endinterface

// File: rtl/onehot_encoder_prio_pick.sv
// -----------------------------------------------------------------------------
// prio_pick
// Combinational winner selection over the pending vector.
//   pend - pending event bits
//   idx  - index of the winning bit (0 when nothing is pending)
//   any  - at least one bit pending
// PRIO_HIGH = 0: lowest set index wins; PRIO_HIGH = 1: highest set index wins.
// -----------------------------------------------------------------------------
module prio_pick
   import onehot_encoder_pkg::*;
#(
   parameter int PRIO_HIGH = 0
) (
   input  logic [NUM_SRC-1:0] pend,
   output logic [CODE_W-1:0]  idx,
   output logic               any
);

   // The scan direction is chosen so that the last match, which is the one
   // that sticks, is the preferred end of the vector.
   always_comb begin
      idx = '0;
      if (PRIO_HIGH != 0) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (pend[i]) idx = CODE_W'(i);
         end
      end else begin
         for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pend[i]) idx = CODE_W'(i);
         end
      end
   end

   assign any = |pend;

endmodule

// File: rtl/onehot_encoder.sv
// -----------------------------------------------------------------------------
// onehot_encoder
// Turns rising edges on 8 request lines into a stream of binary source codes.
// Each edge sets a pending bit; a one-entry output stage (EMPTY/FULL) loads
// the winning pending index and hands it out with a valid/ready handshake.
//   sys_clk - clock, all state on the rising edge
//   sys_rst - asynchronous, active-high reset
//   bus     - onehot_encoder_if.master (in_line, code, code_valid,
//             code_ready, overflow, pend_cnt)
// Parameter PRIO_HIGH: 0 = lowest pending index wins, 1 = highest wins.
// Macro ONEHOT_ENCODER_SYNC_EN: when defined, in_line passes through a
// 2-flop synchronizer before edge detection (two extra cycles of latency).
// -----------------------------------------------------------------------------
module onehot_encoder
   import onehot_encoder_pkg::*;
#(
   parameter int PRIO_HIGH = 0
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   onehot_encoder_if.master   bus
);

   logic [NUM_SRC-1:0] in_s;
   logic [NUM_SRC-1:0] in_prev_reg;
   logic [NUM_SRC-1:0] pend_reg;
   logic [NUM_SRC-1:0] pend_next;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] clr;
   logic [CODE_W-1:0]  code_reg;
   logic               code_valid_reg;
   logic               overflow_reg;
   logic               overflow_next;
   logic [CNT_W-1:0]   pend_cnt_reg;
   state_t             state_reg;
   logic [CODE_W-1:0]  pick_idx;
   logic               pick_any;
   logic               load;

`ifdef ONEHOT_ENCODER_SYNC_EN
   // Reset to all-ones so lines already high at release look "old".
   logic [NUM_SRC-1:0] sync1_reg;
   logic [NUM_SRC-1:0] sync2_reg;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         sync1_reg <= '1;
         sync2_reg <= '1;
      end else begin
         sync1_reg <= bus.in_line;
         sync2_reg <= sync1_reg;
      end
   end

   assign in_s = sync2_reg;
`else
   assign in_s = bus.in_line;
`endif

   // Winner comes from the registered pending vector only, so edges landing
   // this cycle are never granted before they are visible in pend_reg.
   prio_pick #(
      .PRIO_HIGH (PRIO_HIGH)
   ) u_pick (
      .pend (pend_reg),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   // A load happens whenever something is pending and the output slot is
   // free now or is being emptied by a transfer this cycle.
   assign load = pick_any && ((state_reg == EMPTY) || bus.code_ready);

   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_bit
         assign rise[gi] = in_s[gi] & ~in_prev_reg[gi];
         assign clr[gi]  = load && (pick_idx == CODE_W'(gi));
      end
   endgenerate

   // Set beats clear: an edge arriving as its bit is loaded re-arms it.
   assign pend_next     = (pend_reg & ~clr) | rise;
   assign overflow_next = |(rise & pend_reg & ~clr);

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         in_prev_reg    <= '1;
         pend_reg       <= '0;
         pend_cnt_reg   <= '0;
         overflow_reg   <= 1'b0;
         code_reg       <= '0;
         code_valid_reg <= 1'b0;
         state_reg      <= EMPTY;
      end else begin
         in_prev_reg  <= in_s;
         pend_reg     <= pend_next;
         // Counting pend_next keeps pend_cnt equal to popcount(pend_reg).
         pend_cnt_reg <= count_ones(pend_next);
         overflow_reg <= overflow_next;
         case (state_reg)
            EMPTY: begin
               if (pick_any) begin
                  code_reg       <= pick_idx;
                  code_valid_reg <= 1'b1;
                  state_reg      <= FULL;
               end
            end
            FULL: begin
               if (bus.code_ready) begin
                  if (pick_any) begin
                     code_reg <= pick_idx;
                  end else begin
                     code_valid_reg <= 1'b0;
                     state_reg      <= EMPTY;
                  end
               end
            end
            default: begin
               code_valid_reg <= 1'b0;
               state_reg      <= EMPTY;
            end
         endcase
      end
   end

   assign bus.code       = code_reg;
   assign bus.code_valid = code_valid_reg;
   assign bus.overflow   = overflow_reg;
   assign bus.pend_cnt   = pend_cnt_reg;

endmodule
